// File: rtl/ayatsuki_bus_mux_pkg.sv
// Shared definitions for the AyaTsuki core-to-peripheral data-bus interconnect:
// read-return state encodings, default error data and the default slave
// address windows (timer, uart, crc and on-chip memory).
package ayatsuki_bus_mux_pkg;

  typedef enum logic [1:0] {
    bus_idle = 2'd0,
    bus_wait = 2'd1,
    bus_resp = 2'd2
  } bus_state_t;

  localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

  // Slave 0 (memory) in the LSBs, then timer, uart, crc.
  localparam logic [127:0] DEF_SLV_BASE = {32'h8000_0020, 32'h8000_0010,
                                           32'h8000_0000, 32'h0000_0000};
  localparam logic [127:0] DEF_SLV_MASK = {32'hFFFF_FFF0, 32'hFFFF_FFF0,
                                           32'hFFFF_FFF0, 32'hFFFF_E000};

endpackage

// File: rtl/ayatsuki_bus_decode.sv
// Combinational base/mask address decoder. Lowest matching slave index wins
// when windows overlap. Produces hit flag, one-hot select and binary index.
module ayatsuki_bus_decode
  import ayatsuki_bus_mux_pkg::*;
#(
  parameter int SLV_NUM = 4,
  parameter int ADDR_W  = 32,
  parameter logic [SLV_NUM*ADDR_W-1:0] SLV_BASE = DEF_SLV_BASE,
  parameter logic [SLV_NUM*ADDR_W-1:0] SLV_MASK = DEF_SLV_MASK,
  localparam int IDX_W = (SLV_NUM > 1) ? $clog2(SLV_NUM) : 1
) (
  input  logic [ADDR_W-1:0]  addr_i,
  output logic               hit_o,
  output logic [SLV_NUM-1:0] onehot_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic               hit_s;
  logic [IDX_W-1:0]   idx_s;
  logic [SLV_NUM-1:0] onehot_s;

  // Priority search: scan high to low so the lowest matching index is kept.
  always_comb begin
    hit_s    = 1'b0;
    idx_s    = '0;
    onehot_s = '0;
    for (int i = SLV_NUM - 1; i >= 0; i--) begin
      if ((addr_i & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
        hit_s = 1'b1;
        idx_s = IDX_W'(i);
      end else begin
        hit_s = hit_s;
      end
    end
    if (hit_s) begin
      onehot_s[idx_s] = 1'b1;
    end else begin
      onehot_s = '0;
    end
  end

  assign hit_o    = hit_s;
  assign idx_o    = idx_s;
  assign onehot_o = onehot_s;

endmodule

// File: rtl/ayatsuki_bus_mux.sv
// AyaTsuki data-bus interconnect: decodes read/write address windows into
// one-hot slave enables and returns read data through a wait-state handshake
// with timeout and error response.
// Optional error counter: define AYATSUKI_BUS_ERR_CNT_EN.
module ayatsuki_bus_mux
  import ayatsuki_bus_mux_pkg::*;
#(
  parameter int SLV_NUM = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter logic [SLV_NUM*ADDR_W-1:0] SLV_BASE = DEF_SLV_BASE,
  parameter logic [SLV_NUM*ADDR_W-1:0] SLV_MASK = DEF_SLV_MASK,
  parameter int TIMEOUT = 15,
  parameter logic [DATA_W-1:0] ERR_DATA = DEF_ERR_DATA
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      m_r_enable_i,
  input  logic [ADDR_W-1:0]         m_r_addr_i,
  input  logic                      m_w_enable_i,
  input  logic [ADDR_W-1:0]         m_w_addr_i,
  output logic [DATA_W-1:0]         m_r_data_o,
  output logic                      m_r_valid_o,
  output logic                      m_stall_o,
  output logic                      bus_err_o,
  output logic [SLV_NUM-1:0]        s_r_enable_o,
  output logic [SLV_NUM-1:0]        s_w_enable_o,
  input  logic [SLV_NUM*DATA_W-1:0] s_r_data_i,
  input  logic [SLV_NUM-1:0]        s_ready_i
`ifdef AYATSUKI_BUS_ERR_CNT_EN
  ,
  input  logic                      err_clr_i,
  output logic [15:0]               err_cnt_o
`endif
);

  localparam int IDX_W = (SLV_NUM > 1) ? $clog2(SLV_NUM) : 1;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic               rd_hit_s, wr_hit_s;
  logic [SLV_NUM-1:0] rd_oh_s, wr_oh_s;
  logic [IDX_W-1:0]   rd_idx_s, wr_idx_unused_s;

  bus_state_t        state_r, state_nxt_s;
  logic [IDX_W-1:0]  idx_r, idx_nxt_s;
  logic [7:0]        cnt_r, cnt_nxt_s;
  logic [DATA_W-1:0] data_r, data_nxt_s;
  logic              valid_r, bus_err_r;
  logic              rd_go_s, rd_err_s, wr_go_s, wr_miss_s;
  logic              sel_ready_s;
  logic [DATA_W-1:0] sel_data_s;

  ayatsuki_bus_decode #(
    .SLV_NUM(SLV_NUM), .ADDR_W(ADDR_W), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)
  ) u_rd_decode (
    .addr_i(m_r_addr_i), .hit_o(rd_hit_s), .onehot_o(rd_oh_s), .idx_o(rd_idx_s)
  );

  ayatsuki_bus_decode #(
    .SLV_NUM(SLV_NUM), .ADDR_W(ADDR_W), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)
  ) u_wr_decode (
    .addr_i(m_w_addr_i), .hit_o(wr_hit_s), .onehot_o(wr_oh_s), .idx_o(wr_idx_unused_s)
  );

  // Only the latched slave's ready/data matter; others are ignored.
  assign sel_ready_s = s_ready_i[idx_r];
  assign sel_data_s  = s_r_data_i[int'(idx_r)*DATA_W +: DATA_W];

  // Writes are posted and blocked only while a read is waiting.
  assign wr_go_s   = m_w_enable_i && (state_r != bus_wait);
  assign wr_miss_s = wr_go_s && !wr_hit_s;

  // Enables are forced low while reset is asserted, even with requests held.
  assign s_r_enable_o = (rd_go_s && rst_n) ? rd_oh_s : '0;
  assign s_w_enable_o = (wr_go_s && wr_hit_s && rst_n) ? wr_oh_s : '0;

  // Read-return next state, latched slave index, wait counter and data.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    cnt_nxt_s   = cnt_r;
    data_nxt_s  = data_r;
    rd_go_s     = 1'b0;
    rd_err_s    = 1'b0;
    case (state_r)
      bus_idle: begin
        if (m_r_enable_i && rd_hit_s) begin
          rd_go_s     = 1'b1;
          idx_nxt_s   = rd_idx_s;
          cnt_nxt_s   = 8'd0;
          state_nxt_s = bus_wait;
        end else if (m_r_enable_i) begin
          rd_err_s    = 1'b1;
          data_nxt_s  = ERR_DATA;
          state_nxt_s = bus_resp;
        end else begin
          state_nxt_s = bus_idle;
        end
      end
      bus_wait: begin
        if (sel_ready_s) begin
          data_nxt_s  = sel_data_s;
          state_nxt_s = bus_resp;
        end else if (cnt_r == TO_LAST) begin
          rd_err_s    = 1'b1;
          data_nxt_s  = ERR_DATA;
          state_nxt_s = bus_resp;
        end else if (cnt_r != 8'hFF) begin
          cnt_nxt_s = cnt_r + 8'd1;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      bus_resp: begin
        if (m_r_enable_i && rd_hit_s) begin
          rd_go_s     = 1'b1;
          idx_nxt_s   = rd_idx_s;
          cnt_nxt_s   = 8'd0;
          state_nxt_s = bus_wait;
        end else begin
          state_nxt_s = bus_idle;
        end
      end
      default: begin
        state_nxt_s = bus_idle;
      end
    endcase
  end

  // State and registered read-return outputs; read and write errors merge
  // into one pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= bus_idle;
      idx_r     <= '0;
      cnt_r     <= 8'd0;
      data_r    <= '0;
      valid_r   <= 1'b0;
      bus_err_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      idx_r     <= idx_nxt_s;
      cnt_r     <= cnt_nxt_s;
      data_r    <= data_nxt_s;
      valid_r   <= (state_nxt_s == bus_resp);
      bus_err_r <= ((state_nxt_s == bus_resp) && rd_err_s) || wr_miss_s;
    end
  end

  assign m_r_data_o  = data_r;
  assign m_r_valid_o = valid_r;
  assign bus_err_o   = bus_err_r;
  assign m_stall_o   = (state_r == bus_wait);

`ifdef AYATSUKI_BUS_ERR_CNT_EN
  logic [15:0] err_cnt_r;

  // Saturating error-pulse counter; clear wins over a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_r <= 16'd0;
    end else if (err_clr_i) begin
      err_cnt_r <= 16'd0;
    end else if (bus_err_r && (err_cnt_r != 16'hFFFF)) begin
      err_cnt_r <= err_cnt_r + 16'd1;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign err_cnt_o = err_cnt_r;
`endif

endmodule

// File: tb/tb_ayatsuki_bus_mux.sv
// Self-checking bench for ayatsuki_bus_mux: expected read responses are queued
// when a read is issued and compared when m_r_valid_o pulses.
module tb_ayatsuki_bus_mux;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         m_r_enable, m_w_enable;
  logic [31:0]  m_r_addr, m_w_addr;
  logic [31:0]  m_r_data;
  logic         m_r_valid, m_stall, bus_err;
  logic [3:0]   s_r_enable, s_w_enable;
  logic [127:0] s_r_data;
  logic [3:0]   s_ready;
`ifdef AYATSUKI_BUS_ERR_CNT_EN
  logic         err_clr;
  logic [15:0]  err_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [32:0] sb_q[$];   // {err, data}

  ayatsuki_bus_mux dut (
    .clk(clk), .rst_n(rst_n),
    .m_r_enable_i(m_r_enable), .m_r_addr_i(m_r_addr),
    .m_w_enable_i(m_w_enable), .m_w_addr_i(m_w_addr),
    .m_r_data_o(m_r_data), .m_r_valid_o(m_r_valid),
    .m_stall_o(m_stall), .bus_err_o(bus_err),
    .s_r_enable_o(s_r_enable), .s_w_enable_o(s_w_enable),
    .s_r_data_i(s_r_data), .s_ready_i(s_ready)
`ifdef AYATSUKI_BUS_ERR_CNT_EN
    , .err_clr_i(err_clr), .err_cnt_o(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every valid pulse must match the oldest queued response.
  always @(negedge clk) begin
    if (rst_n && m_r_valid) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_valid", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = sb_q.pop_front();
        check_val("rd_data", m_r_data, e[31:0]);
        check_val("rd_err", {31'd0, bus_err}, {31'd0, e[32]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall_cnt;
    rst_n = 1'b0; m_r_enable = 1'b0; m_w_enable = 1'b0;
    m_r_addr = 32'd0; m_w_addr = 32'd0; s_r_data = 128'd0; s_ready = 4'd0;
`ifdef AYATSUKI_BUS_ERR_CNT_EN
    err_clr = 1'b0;
`endif
    s_r_data[64 +: 32] = 32'h0000_00A5;
    s_r_data[96 +: 32] = 32'h3333_0003;
    s_r_data[0  +: 32] = 32'h0000_1234;
    repeat (3) cyc();
    check_val("rst_data", m_r_data, 32'd0);
    check_val("rst_flags", {28'd0, m_r_valid, m_stall, bus_err, 1'b0}, 32'd0);
    check_val("rst_en", {24'd0, s_r_enable, s_w_enable}, 32'd0);
    rst_n = 1'b1;
    cyc();

    // Read slave 2, ready on the next cycle.
    m_r_enable = 1'b1; m_r_addr = 32'h8000_0014; #1;
    check_val("t1_ren", {28'd0, s_r_enable}, 32'h4);
    check_val("t1_stall_c0", {31'd0, m_stall}, 32'd0);
    sb_q.push_back({1'b0, 32'h0000_00A5});
    cyc();
    check_val("t1_stall_c1", {31'd0, m_stall}, 32'd1);
    check_val("t1_ren_wait", {28'd0, s_r_enable}, 32'd0);
    s_ready = 4'b0100;
    cyc();
    m_r_enable = 1'b0; s_ready = 4'd0;
    check_val("t1_valid_c2", {31'd0, m_r_valid}, 32'd1);
    check_val("t1_stall_c2", {31'd0, m_stall}, 32'd0);
    cyc();

    // Unmapped read.
    m_r_enable = 1'b1; m_r_addr = 32'h4000_0000; #1;
    check_val("t2_ren", {28'd0, s_r_enable}, 32'd0);
    sb_q.push_back({1'b1, 32'hDEAD_BEEF});
    cyc();
    m_r_enable = 1'b0;
    check_val("t2_valid", {31'd0, m_r_valid}, 32'd1);
    check_val("t2_stall", {31'd0, m_stall}, 32'd0);
    cyc();

    // Slave 1 never ready: timeout after 15 stall cycles.
    m_r_enable = 1'b1; m_r_addr = 32'h8000_0004; #1;
    check_val("t3_ren", {28'd0, s_r_enable}, 32'h2);
    sb_q.push_back({1'b1, 32'hDEAD_BEEF});
    stall_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (!m_stall) break;
      stall_cnt++;
      if (stall_cnt == 1) begin
        m_w_enable = 1'b1; m_w_addr = 32'h8000_0014; #1;
        check_val("t3_wr_in_wait", {28'd0, s_w_enable}, 32'd0);
        m_w_enable = 1'b0;
      end
    end
    m_r_enable = 1'b0;
    check_val("t3_stall_cycles", stall_cnt, 32'd15);
    s_ready = 4'b0010;
    cyc();
    cyc();
    s_ready = 4'd0;
    check_val("t3_late_ready_valid", {31'd0, m_r_valid}, 32'd0);
    check_val("t3_late_ready_stall", {31'd0, m_stall}, 32'd0);

    // Simultaneous write slave 0 and read slave 3, then back-to-back read.
    m_w_enable = 1'b1; m_w_addr = 32'h0000_1FFC;
    m_r_enable = 1'b1; m_r_addr = 32'h8000_0020; #1;
    check_val("t4_wen", {28'd0, s_w_enable}, 32'h1);
    check_val("t4_ren", {28'd0, s_r_enable}, 32'h8);
    sb_q.push_back({1'b0, 32'h3333_0003});
    cyc();
    m_w_enable = 1'b0; s_ready = 4'b1000;
    check_val("t4_stall", {31'd0, m_stall}, 32'd1);
    cyc();
    s_ready = 4'd0; m_r_addr = 32'h0000_0100; #1;
    check_val("t4_valid", {31'd0, m_r_valid}, 32'd1);
    check_val("t4_b2b_ren", {28'd0, s_r_enable}, 32'h1);
    sb_q.push_back({1'b0, 32'h0000_1234});
    cyc();
    s_ready = 4'b0001;
    cyc();
    m_r_enable = 1'b0; s_ready = 4'd0;
    check_val("t4_b2b_valid", {31'd0, m_r_valid}, 32'd1);
    cyc();

    // Write miss: error pulse next cycle, no enable, no read response.
    m_w_enable = 1'b1; m_w_addr = 32'h4000_0000; #1;
    check_val("t5_wen", {28'd0, s_w_enable}, 32'd0);
    cyc();
    m_w_enable = 1'b0;
    check_val("t5_err", {31'd0, bus_err}, 32'd1);
    check_val("t5_valid", {31'd0, m_r_valid}, 32'd0);
    cyc();
    check_val("t5_err_end", {31'd0, bus_err}, 32'd0);

    // Read and write miss together: one error pulse.
    m_w_enable = 1'b1; m_w_addr = 32'h4000_0008;
    m_r_enable = 1'b1; m_r_addr = 32'h4000_0000;
    sb_q.push_back({1'b1, 32'hDEAD_BEEF});
    cyc();
    m_w_enable = 1'b0; m_r_enable = 1'b0;
    check_val("t6_err", {31'd0, bus_err}, 32'd1);
    cyc();
    check_val("t6_err_single", {31'd0, bus_err}, 32'd0);

    // Reset in the middle of a wait; pending read dropped.
    m_r_enable = 1'b1; m_r_addr = 32'h0000_0040;
    cyc();
    check_val("t7_stall_pre", {31'd0, m_stall}, 32'd1);
    rst_n = 1'b0; #1;
    check_val("t7_rst_data", m_r_data, 32'd0);
    check_val("t7_rst_flags", {29'd0, m_r_valid, m_stall, bus_err}, 32'd0);
    check_val("t7_rst_en", {24'd0, s_r_enable, s_w_enable}, 32'd0);
    m_r_enable = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    m_r_enable = 1'b1; m_r_addr = 32'h0000_0040; s_ready = 4'b0001; #1;
    check_val("t7_ren", {28'd0, s_r_enable}, 32'h1);
    sb_q.push_back({1'b0, 32'h0000_1234});
    cyc();
    cyc();
    m_r_enable = 1'b0; s_ready = 4'd0;
    check_val("t7_fresh_valid", {31'd0, m_r_valid}, 32'd1);
    cyc();

`ifdef AYATSUKI_BUS_ERR_CNT_EN
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    check_val("t8_clr", {16'd0, err_cnt}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      m_w_enable = 1'b1; m_w_addr = 32'h4000_0000;
      cyc();
      m_w_enable = 1'b0;
      cyc();
    end
    check_val("t8_cnt3", {16'd0, err_cnt}, 32'd3);
    m_w_enable = 1'b1; m_w_addr = 32'h4000_0000;
    cyc();
    m_w_enable = 1'b0; err_clr = 1'b1;
    check_val("t8_err4", {31'd0, bus_err}, 32'd1);
    cyc();
    err_clr = 1'b0;
    check_val("t8_clr_wins", {16'd0, err_cnt}, 32'd0);
`endif

    repeat (2) cyc();
    check_val("sb_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
